// File: rtl/wb_bus_decoder_if.sv
// Wishbone bus bundle for the decoder: master-side request/response plus the
// shared/per-slave fan-out towards the peripherals.
interface wb_bus_decoder_if #(
  parameter int NR_SLAVES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  logic [ADDR_W-1:0]           m_adr_i;
  logic [DATA_W-1:0]           m_dat_i;
  logic [DATA_W/8-1:0]         m_sel_i;
  logic                        m_we_i;
  logic                        m_cyc_i;
  logic                        m_stb_i;
  logic [DATA_W-1:0]           m_dat_o;
  logic                        m_ack_o;
  logic                        m_err_o;
  logic                        m_rty_o;

  logic [ADDR_W-1:0]           s_adr_o;
  logic [DATA_W-1:0]           s_dat_o;
  logic [DATA_W/8-1:0]         s_sel_o;
  logic                        s_we_o;
  logic [NR_SLAVES-1:0]        s_cyc_o;
  logic [NR_SLAVES-1:0]        s_stb_o;
  logic [NR_SLAVES*DATA_W-1:0] s_dat_i;
  logic [NR_SLAVES-1:0]        s_ack_i;
  logic [NR_SLAVES-1:0]        s_err_i;
  logic [NR_SLAVES-1:0]        s_rty_i;

  // Decoder's view: it is the slave of the CPU master and drives the peripherals.
  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
           s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
           s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
           s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
           s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
  );
endinterface

// File: rtl/wb_bus_decoder.sv
// Wishbone B3 single-master address decoder/mux with registered slave select,
// unmapped-address bus errors, a response watchdog and error address capture.
module wb_bus_decoder #(
  parameter int                          NR_SLAVES         = 4,
  parameter int                          ADDR_W            = 32,
  parameter int                          DATA_W            = 32,
  parameter logic [NR_SLAVES-1:0]        SLAVE_ENABLE      = 4'b0011,
  parameter logic [NR_SLAVES*ADDR_W-1:0] SLAVE_BASE        = {32'h9200_0000, 32'h9100_0000,
                                                              32'h9000_0000, 32'h0000_0000},
  parameter logic [NR_SLAVES*32-1:0]     SLAVE_RANGE_WIDTH = {32'd8, 32'd8, 32'd8, 32'd8},
  parameter int                          TIMEOUT           = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_bus_decoder_if.slave   bus,
  output logic              decode_err_o,
  output logic              timeout_o,
  output logic [ADDR_W-1:0] err_adr_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERR} state_t;

  state_t               r_state, w_state_nxt;
  logic [NR_SLAVES-1:0] r_sel, w_sel_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]    r_err_adr, w_err_adr_nxt;
  logic                 r_err_to, w_err_to_nxt;

  logic [NR_SLAVES-1:0] w_match;
  logic [NR_SLAVES-1:0] w_match_first;
  logic [DATA_W-1:0]    w_rdata;
  logic                 w_req;
  logic                 w_resp;
  logic                 w_expire;

  // Upper rw address bits set; rw == ADDR_W yields an all-ones mask.
  function automatic logic [ADDR_W-1:0] range_mask(input logic [31:0] rw);
    range_mask = ~({ADDR_W{1'b1}} >> rw);
  endfunction

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NR_SLAVES; i++) begin
      if (SLAVE_ENABLE[i] &&
          ((bus.m_adr_i ^ SLAVE_BASE[i*ADDR_W +: ADDR_W]) &
           range_mask(SLAVE_RANGE_WIDTH[i*32 +: 32])) == '0)
        w_match[i] = 1'b1;
    end
  end

  // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
  assign w_match_first = w_match & (~w_match + NR_SLAVES'(1));

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NR_SLAVES; i++)
      w_rdata = w_rdata | (bus.s_dat_i[i*DATA_W +: DATA_W] & {DATA_W{r_sel[i]}});
  end

  assign w_req    = bus.m_cyc_i & bus.m_stb_i;
  assign w_resp   = bus.m_stb_i & (|(r_sel & (bus.s_ack_i | bus.s_err_i | bus.s_rty_i)));
  assign w_expire = (TIMEOUT > 0) && (r_state == ST_ACTIVE) && w_req && !w_resp &&
                    (r_cnt == TO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_err_adr <= '0;
      r_err_to  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err_adr <= w_err_adr_nxt;
      r_err_to  <= w_err_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_cnt_nxt     = r_cnt;
    w_err_adr_nxt = r_err_adr;
    w_err_to_nxt  = r_err_to;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (|w_match_first) begin
            w_state_nxt = ST_ACTIVE;
            w_sel_nxt   = w_match_first;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt   = ST_ERR;
            w_err_adr_nxt = bus.m_adr_i;
            w_err_to_nxt  = 1'b0;
          end
        end
      end
      ST_ACTIVE: begin
        if (w_resp)
          w_cnt_nxt = '0;
        else if (w_req && r_cnt != TO_MAX)
          w_cnt_nxt = r_cnt + CNT_W'(1);
        // A response in the expiry cycle suppresses the timeout via w_expire.
        if (w_expire) begin
          w_state_nxt   = ST_ERR;
          w_sel_nxt     = '0;
          w_err_adr_nxt = bus.m_adr_i;
          w_err_to_nxt  = 1'b1;
        end else if (!bus.m_cyc_i) begin
          w_state_nxt = ST_IDLE;
          w_sel_nxt   = '0;
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    bus.s_cyc_o  = '0;
    bus.s_stb_o  = '0;
    bus.m_ack_o  = 1'b0;
    bus.m_err_o  = 1'b0;
    bus.m_rty_o  = 1'b0;
    bus.m_dat_o  = '0;
    decode_err_o = 1'b0;
    timeout_o    = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        bus.s_cyc_o = r_sel & {NR_SLAVES{bus.m_cyc_i}};
        bus.s_stb_o = r_sel & {NR_SLAVES{bus.m_stb_i}};
        bus.m_ack_o = bus.m_stb_i & (|(r_sel & bus.s_ack_i));
        bus.m_err_o = bus.m_stb_i & (|(r_sel & bus.s_err_i));
        bus.m_rty_o = bus.m_stb_i & (|(r_sel & bus.s_rty_i));
        bus.m_dat_o = w_rdata;
      end
      ST_ERR: begin
        bus.m_err_o  = 1'b1;
        decode_err_o = ~r_err_to;
        timeout_o    = r_err_to;
      end
      default: ;
    endcase
  end

  assign bus.s_adr_o = bus.m_adr_i;
  assign bus.s_dat_o = bus.m_dat_i;
  assign bus.s_sel_o = bus.m_sel_i;
  assign bus.s_we_o  = bus.m_we_i;
  assign err_adr_o   = r_err_adr;

endmodule

// File: tb/tb_wb_bus_decoder.sv
// Randomised self-checking bench for wb_bus_decoder against a transaction-level
// address-map and watchdog model.
module tb_wb_bus_decoder;
  localparam int NS      = 4;
  localparam int TIMEOUT = 255;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        decode_err_o;
  logic        timeout_o;
  logic [31:0] err_adr_o;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_err = 32'h0;

  wb_bus_decoder_if #(.NR_SLAVES(NS), .ADDR_W(32), .DATA_W(32)) bus ();

  wb_bus_decoder dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus),
    .decode_err_o (decode_err_o),
    .timeout_o    (timeout_o),
    .err_adr_o    (err_adr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address map: 16 MB windows on the top byte; only slaves 0 and 1 enabled.
  function automatic int ref_decode(input logic [31:0] a);
    logic [31:0] base [NS];
    bit          en   [NS];
    base = '{32'h0000_0000, 32'h9000_0000, 32'h9100_0000, 32'h9200_0000};
    en   = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < NS; i++)
      if (en[i] && (a / 32'h0100_0000) == (base[i] / 32'h0100_0000)) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_bus();
    bus.m_cyc_i = 1'b0;
    bus.m_stb_i = 1'b0;
    bus.s_ack_i = '0;
    bus.s_err_i = '0;
    bus.s_rty_i = '0;
  endtask

  // rtype: 0 = slave never answers, 1 ack, 2 err, 3 rty. Response arrives
  // lat cycles after the slave strobe first appears.
  task automatic do_access(input logic [31:0] a, input int rtype, input int lat,
                           input logic [31:0] rd);
    int          exp_s;
    logic [3:0]  oh;
    logic [2:0]  code;
    logic [31:0] wd;
    bit          respond;
    exp_s = ref_decode(a);
    wd    = $urandom;
    tick();
    bus.m_adr_i = a;
    bus.m_dat_i = wd;
    bus.m_we_i  = 1'($urandom);
    bus.m_sel_i = 4'($urandom);
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    for (int i = 0; i < NS; i++) bus.s_dat_i[i*32 +: 32] = $urandom;
    @(negedge clk_i);
    check("decode_stb", bus.s_stb_o, 0);
    check("decode_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    if (exp_s < 0) begin
      tick();
      @(negedge clk_i);
      check("unmap_m_err", bus.m_err_o, 1);
      check("unmap_decode_err", decode_err_o, 1);
      check("unmap_timeout", timeout_o, 0);
      check("unmap_s_stb", bus.s_stb_o, 0);
      check("unmap_s_cyc", bus.s_cyc_o, 0);
      check("unmap_err_adr", err_adr_o, a);
      last_err = a;
      tick();
      idle_bus();
      @(negedge clk_i);
      check("unmap_err_pulse", {bus.m_err_o, decode_err_o}, 0);
      return;
    end
    oh = 4'(1 << exp_s);
    bus.s_dat_i[exp_s*32 +: 32] = rd;
    code = (rtype == 1) ? 3'b100 : (rtype == 2) ? 3'b010 : (rtype == 3) ? 3'b001 : 3'b000;
    for (int c = 1; c <= TIMEOUT + 1; c++) begin
      tick();
      respond = (rtype != 0) && (c == lat + 1) && (c <= TIMEOUT);
      bus.s_ack_i = (respond && rtype == 1 ? oh : 4'b0) | (4'($urandom) & ~oh);
      bus.s_err_i = (respond && rtype == 2) ? oh : 4'b0;
      bus.s_rty_i = (respond && rtype == 3) ? oh : 4'b0;
      @(negedge clk_i);
      if (c == TIMEOUT + 1) begin
        check("to_s_stb", bus.s_stb_o, 0);
        check("to_m_err", bus.m_err_o, 1);
        check("to_timeout", timeout_o, 1);
        check("to_decode_err", decode_err_o, 0);
        check("to_err_adr", err_adr_o, a);
        last_err = a;
        break;
      end
      check("act_s_stb", bus.s_stb_o, oh);
      check("act_s_cyc", bus.s_cyc_o, oh);
      if (c == 1) begin
        check("pass_adr", bus.s_adr_o, a);
        check("pass_dat", bus.s_dat_o, wd);
        check("pass_sel_we", {bus.s_sel_o, bus.s_we_o}, {bus.m_sel_i, bus.m_we_i});
      end
      if (respond) begin
        check("act_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, code);
        check("act_rdata", bus.m_dat_o, rd);
        check("act_no_to", timeout_o, 0);
        break;
      end
      check("act_wait", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    end
    tick();
    idle_bus();
    @(negedge clk_i);
    check("end_s_cyc", bus.s_cyc_o, 0);
    check("end_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    check("end_pulses", {decode_err_o, timeout_o}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0]  lock;
    logic [31:0] a;
    int          kind;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_we_i  = 1'b0;
    bus.s_dat_i = '0;
    idle_bus();

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_s_cyc", bus.s_cyc_o, 0);
    check("rst_resp", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o}, 0);
    check("rst_pulses", {decode_err_o, timeout_o}, 0);
    check("rst_err_adr", err_adr_o, 0);
    check("rst_m_dat", bus.m_dat_o, 0);
    tick();
    rst_i = 1'b0;

    // Directed cases
    do_access(32'h9000_0010, 1, 1, 32'hDEAD_BEEF);
    do_access(32'h9100_0000, 1, 1, 32'h0);
    check("err_adr_hold", err_adr_o, 32'h9100_0000);
    do_access(32'h0000_0040, 0, 0, 32'h1234_5678);
    check("to_adr_hold", err_adr_o, 32'h0000_0040);
    do_access(32'h9000_0020, 1, TIMEOUT - 1, 32'hCAFE_F00D);
    check("late_ack_adr", err_adr_o, 32'h0000_0040);

    // Locked burst: later beats move the address, selection must not follow.
    lock = 4'(1 << ref_decode(32'h9000_0000));
    tick();
    bus.m_adr_i = 32'h9000_0000;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    @(negedge clk_i);
    check("burst_decode", bus.s_stb_o, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      bus.m_adr_i = (b == 3) ? 32'h0000_0100 : 32'h9000_0000 + 32'(4 * b);
      bus.m_stb_i = 1'b1;
      bus.s_ack_i = lock;
      @(negedge clk_i);
      check("burst_stb", bus.s_stb_o, lock);
      check("burst_ack", bus.m_ack_o, 1);
      tick();
      bus.m_stb_i = 1'b0;
      bus.s_ack_i = '0;
      @(negedge clk_i);
      check("burst_gap_stb", bus.s_stb_o, 0);
      check("burst_gap_cyc", bus.s_cyc_o, lock);
      check("burst_gap_ack", bus.m_ack_o, 0);
    end
    tick();
    idle_bus();
    @(negedge clk_i);
    check("burst_end_cyc", bus.s_cyc_o, 0);
    do_access(32'h0000_0000, 1, 0, 32'h0BAD_F00D);

    // Asynchronous reset in the middle of an active transfer
    tick();
    bus.m_adr_i = 32'h9000_0004;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    @(negedge clk_i);
    tick();
    bus.s_ack_i = 4'b0010;
    @(negedge clk_i);
    check("prerst_ack", bus.m_ack_o, 1);
    #1 rst_i = 1'b1;
    #1;
    check("async_s_cyc", bus.s_cyc_o, 0);
    check("async_s_stb", bus.s_stb_o, 0);
    check("async_ack", bus.m_ack_o, 0);
    check("async_err_adr", err_adr_o, 0);
    last_err = 32'h0;
    tick();
    rst_i = 1'b0;
    idle_bus();
    @(negedge clk_i);
    do_access(32'h9000_0008, 1, 1, 32'h5555_AAAA);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0:       a = {8'h00, 24'($urandom)};
        1:       a = {8'h90, 24'($urandom)};
        2:       a = {8'($urandom_range(8'h91, 8'h92)), 24'($urandom)};
        default: a = $urandom;
      endcase
      do_access(a, $urandom_range(1, 3), $urandom_range(0, 3), $urandom);
      check("rand_err_adr", err_adr_o, last_err);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_bus_decoder.md
Name: wb_bus_decoder

Overview:
Parametrised Wishbone B3 single-master address decoder/multiplexer and successor to the static per-slave decode settings. It supports 1..16 slaves, configurable address/data widths and per-slave base/range-width/enable vectors. It adds registered slave selection, unmapped-address bus errors, a slave-response timeout watchdog and error capture. It sits between the CPU data master and the peripheral slaves.

Parameters:
NR_SLAVES, 4, number of slave ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
SLAVE_ENABLE, 4'b0011, bit i = slave i decodable; disabled slaves never match
SLAVE_BASE, {32'h9200_0000,32'h9100_0000,32'h9000_0000,32'h0000_0000}, packed NR_SLAVES*ADDR_W; slave i at [i*ADDR_W +: ADDR_W]
SLAVE_RANGE_WIDTH, {8,8,8,8}, packed NR_SLAVES*32; number of upper address bits compared (1..ADDR_W)
TIMEOUT, 255, max cycles from slave strobe to slave response; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
m_adr_i  in  ADDR_W  master address
m_dat_i  in  DATA_W  master write data
m_sel_i  in  DATA_W/8  byte select
m_we_i  in  1  write enable
m_cyc_i  in  1  bus cycle
m_stb_i  in  1  strobe
m_dat_o  out  DATA_W  read data
m_ack_o  out  1  acknowledge
m_err_o  out  1  error
m_rty_o  out  1  retry
s_adr_o  out  ADDR_W  shared slave address (= m_adr_i)
s_dat_o  out  DATA_W  shared write data (= m_dat_i)
s_sel_o  out  DATA_W/8  shared byte select
s_we_o  out  1  shared write enable
s_cyc_o  out  NR_SLAVES  per-slave cycle
s_stb_o  out  NR_SLAVES  per-slave strobe
s_dat_i  in  NR_SLAVES*DATA_W  per-slave read data
s_ack_i  in  NR_SLAVES  per-slave ack
s_err_i  in  NR_SLAVES  per-slave err
s_rty_i  in  NR_SLAVES  per-slave retry
decode_err_o  out  1  one-cycle pulse on unmapped access
timeout_o  out  1  one-cycle pulse on watchdog expiry
err_adr_o  out  ADDR_W  address of the most recent decode error or timeout

Behaviour:
- Match i: SLAVE_ENABLE[i] && m_adr_i[ADDR_W-1 -: RW_i] == SLAVE_BASE_i[ADDR_W-1 -: RW_i]. On overlapping matches, the lowest index wins.
- FSM: IDLE, ACTIVE, ERR. Reset (async): IDLE. All outputs 0, sel register 0, counter 0, err_adr_o 0. Reset mid-transfer drops s_cyc_o/s_stb_o immediately.
- IDLE: on m_cyc_i&m_stb_i with a match, register the one-hot sel and go to ACTIVE. With no match, go to ERR. Decode latency is 1 cycle, so slave strobe appears the cycle after the master strobe.
- ACTIVE:
  - s_cyc_o = sel & {m_cyc_i}; s_stb_o = sel & {m_stb_i}.
  - m_ack_o/m_err_o/m_rty_o are the selected slave's responses gated by m_stb_i, combinational and same-cycle.
  - m_dat_o = selected slave's data.
  - Selection is locked while m_cyc_i=1, so subsequent strobes in the same cycle go to the same slave regardless of address. m_cyc_i=0 -> IDLE.
- m_dat_o = 0 and m_ack/err/rty = 0 outside ACTIVE, except m_err_o in ERR.
- ERR: m_err_o=1 for exactly one cycle, all s_cyc/s_stb=0, then IDLE. m_stb_i is ignored during ERR, so re-decode starts the following cycle.
- decode_err_o pulses in the ERR cycle for unmapped accesses. err_adr_o captures m_adr_i at the decode cycle.
- Watchdog (TIMEOUT>0):
  - Counter clears on entering ACTIVE and on any selected ack/err/rty. It increments each ACTIVE cycle with m_stb_i=1 and no response.
  - When the counter reaches TIMEOUT, the next cycle is ERR: slave strobe drops, m_err_o pulses, timeout_o pulses (decode_err_o stays 0), and err_adr_o captures m_adr_i.
  - If a slave response and expiry coincide, the response wins: no error, counter cleared.
- m_cyc_i dropping in the same cycle as an ack: the ack is still forwarded, and the next state is IDLE.
- Counter width is clog2(TIMEOUT+1) and saturates, with no wrap.

Test Plan:
- Read 0x9000_0010, slave1 acks 1 cycle after its stb with 0xDEAD_BEEF -> s_stb_o=4'b0010 one cycle after m_stb; m_ack_o same cycle as s_ack_i[1]; m_dat_o=0xDEAD_BEEF.
- Write to 0x9100_0000 (slave2 disabled) -> no s_stb_o; m_err_o and decode_err_o high exactly 1 cycle, 1 cycle after strobe; err_adr_o=0x9100_0000.
- Slave0 never responds to 0x0000_0040, TIMEOUT=255 -> after 255 stalled cycles s_stb_o[0] drops, m_err_o+timeout_o pulse once; err_adr_o=0x0000_0040.
- Slave1 acks on the exact expiry cycle -> m_ack_o forwarded, no m_err_o/timeout_o.
- Burst of 4 locked strobes at 0x9000_0000..0x9000_000C with cyc held -> 4 acks, sel constant; cyc drop returns to IDLE; next access to 0x0000_0000 selects slave0.
- rst_i asserted mid-ACTIVE -> s_cyc_o/s_stb_o/m_ack_o go 0 asynchronously; after release, a fresh access decodes normally.
